// File: rtl/switch_input.sv
// Switch input conditioner: per-bit 2-flop synchroniser, counter debounce, edge pulses and a
// sticky CPU-acknowledged event register. Define SWITCH_FALL_EVENT_EN to also capture falling edges.
module switch_input #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_switch,
    output logic [WIDTH-1:0] switch_level,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic [WIDTH-1:0] ev_pending,
    input  logic [WIDTH-1:0] ev_ack
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic [WIDTH-1:0] ev_set_s;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Debounce: count consecutive samples that disagree with the level; any agreeing sample restarts.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Pulses are registered together with the new level; pending captures the visible pulse,
    // so an ack landing on the capture edge loses to the set.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
`ifdef SWITCH_FALL_EVENT_EN
        ev_set_s = rise_q | fall_q;
`else
        ev_set_s = rise_q;
`endif
        pend_d = (pend_q & ~ev_ack) | ev_set_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_switch;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign switch_level = level_q;
    assign switch_rise  = rise_q;
    assign switch_fall  = fall_q;
    assign ev_pending   = pend_q;

endmodule

// File: tb/tb_switch_input.sv
// Scoreboard bench for switch_input (WIDTH=4, STABLE_CYCLES=4); expectations are queued with the
// cycle they are due and checked on the falling edge. Honours SWITCH_FALL_EVENT_EN.
module tb_switch_input;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_switch;
    logic [3:0] switch_level;
    logic [3:0] switch_rise;
    logic [3:0] switch_fall;
    logic [3:0] ev_pending;
    logic [3:0] ev_ack;

`ifdef SWITCH_FALL_EVENT_EN
    localparam bit FALL_EV = 1'b1;
`else
    localparam bit FALL_EV = 1'b0;
`endif

    typedef struct {
        int         due;
        int         what;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    switch_input #(.WIDTH(4), .STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_switch   (raw_switch),
        .switch_level (switch_level),
        .switch_rise  (switch_rise),
        .switch_fall  (switch_fall),
        .ev_pending   (ev_pending),
        .ev_ack       (ev_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int due, input int what, input logic [3:0] val, input string tag);
        exp_t e;
        e.due  = due;
        e.what = what;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic expect_state(input int due, input string tag, input logic [3:0] lvl,
                                input logic [3:0] rise, input logic [3:0] fall,
                                input logic [3:0] pend);
        push(due, 0, lvl,  $sformatf("%s.level@%0d", tag, due));
        push(due, 1, rise, $sformatf("%s.rise@%0d", tag, due));
        push(due, 2, fall, $sformatf("%s.fall@%0d", tag, due));
        push(due, 3, pend, $sformatf("%s.pend@%0d", tag, due));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Scoreboard consumer: compare every entry due in the current cycle, then drop it.
    always @(negedge clk) begin
        logic [3:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].what)
                    0:       obs = switch_level;
                    1:       obs = switch_rise;
                    2:       obs = switch_fall;
                    default: obs = ev_pending;
                endcase
                check_eq(sb[i].tag, obs, sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        int t;
        logic [3:0] fev;
        reset      = 1'b1;
        raw_switch = 4'hF;
        ev_ack     = 4'h0;

        // 1: reset with raw high, then qualification after release
        step(3);
        t = cyc;
        expect_state(t, "rst", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int c = 1; c <= 5; c++) expect_state(t + c, "t1", 4'h0, 4'h0, 4'h0, 4'h0);
        expect_state(t + 6, "t1", 4'hF, 4'hF, 4'h0, 4'h0);
        expect_state(t + 7, "t1", 4'hF, 4'h0, 4'h0, 4'hF);
        expect_state(t + 8, "t1", 4'hF, 4'h0, 4'h0, 4'hF);
        reset = 1'b0;
        step(9);
        ev_ack = 4'hF;
        step(1);
        ev_ack = 4'h0;
        expect_state(cyc, "ack_all", 4'hF, 4'h0, 4'h0, 4'h0);

        // 2: two-sample glitch on bit 0 is rejected
        t = cyc;
        for (int c = 0; c <= 11; c++) expect_state(t + c, "t2", 4'hF, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hE;
        step(2);
        raw_switch = 4'hF;
        step(10);

        // 3a: drop bit 1 so it can rise again
        t   = cyc;
        fev = FALL_EV ? 4'h2 : 4'h0;
        for (int c = 0; c <= 5; c++) expect_state(t + c, "t3a", 4'hF, 4'h0, 4'h0, 4'h0);
        expect_state(t + 6, "t3a", 4'hD, 4'h0, 4'h2, 4'h0);
        expect_state(t + 7, "t3a", 4'hD, 4'h0, 4'h0, fev);
        expect_state(t + 9, "t3a", 4'hD, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hD;
        step(8);
        ev_ack = 4'h2;
        step(1);
        ev_ack = 4'h0;
        step(1);

        // 3b: bit 1 rises; ack during the pulse loses, ack one cycle later clears
        t = cyc;
        for (int c = 0; c <= 5; c++) expect_state(t + c, "t3b", 4'hD, 4'h0, 4'h0, 4'h0);
        expect_state(t + 6, "t3b", 4'hF, 4'h2, 4'h0, 4'h0);
        expect_state(t + 7, "t3b", 4'hF, 4'h0, 4'h0, 4'h2);
        expect_state(t + 8, "t3b", 4'hF, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hF;
        step(6);
        ev_ack = 4'h2;
        step(1);
        ev_ack = 4'h2;
        step(1);
        ev_ack = 4'h0;
        step(2);

        // 4a: bit 2 falls
        t   = cyc;
        fev = FALL_EV ? 4'h4 : 4'h0;
        for (int c = 0; c <= 5; c++) expect_state(t + c, "t4a", 4'hF, 4'h0, 4'h0, 4'h0);
        expect_state(t + 6, "t4a", 4'hB, 4'h0, 4'h4, 4'h0);
        expect_state(t + 7, "t4a", 4'hB, 4'h0, 4'h0, fev);
        expect_state(t + 9, "t4a", 4'hB, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hB;
        step(8);
        ev_ack = 4'h4;
        step(1);
        ev_ack = 4'h0;
        step(1);

        // 4b: bit 2 back up
        t = cyc;
        for (int c = 0; c <= 5; c++) expect_state(t + c, "t4b", 4'hB, 4'h0, 4'h0, 4'h0);
        expect_state(t + 6, "t4b", 4'hF, 4'h4, 4'h0, 4'h0);
        expect_state(t + 7, "t4b", 4'hF, 4'h0, 4'h0, 4'h4);
        expect_state(t + 9, "t4b", 4'hF, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hF;
        step(8);
        ev_ack = 4'h4;
        step(1);
        ev_ack = 4'h0;
        step(1);

        // 5 prep: bring bit 3 low
        t   = cyc;
        fev = FALL_EV ? 4'h8 : 4'h0;
        expect_state(t + 6, "t5p", 4'h7, 4'h0, 4'h8, 4'h0);
        expect_state(t + 7, "t5p", 4'h7, 4'h0, 4'h0, fev);
        expect_state(t + 9, "t5p", 4'h7, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'h7;
        step(8);
        ev_ack = 4'h8;
        step(1);
        ev_ack = 4'h0;
        step(1);

        // 5: reset in the middle of bit 3's count, raw held high throughout
        t = cyc;
        for (int c = 0; c <= 3; c++) expect_state(t + c, "t5", 4'h7, 4'h0, 4'h0, 4'h0);
        for (int c = 4; c <= 10; c++) expect_state(t + c, "t5", 4'h0, 4'h0, 4'h0, 4'h0);
        expect_state(t + 11, "t5", 4'hF, 4'hF, 4'h0, 4'h0);
        expect_state(t + 12, "t5", 4'hF, 4'h0, 4'h0, 4'hF);
        expect_state(t + 14, "t5", 4'hF, 4'h0, 4'h0, 4'h0);
        raw_switch = 4'hF;
        step(3);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(8);
        ev_ack = 4'hF;
        step(1);
        ev_ack = 4'h0;
        step(1);

        // 6: alternating 2-cycle patterns never qualify
        t = cyc;
        for (int c = 0; c <= 46; c++) expect_state(t + c, "t6", 4'hF, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            raw_switch = 4'b0101;
            step(2);
            raw_switch = 4'b1010;
            step(2);
        end
        raw_switch = 4'hF;

        // drain with a bound
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        check_eq("sb_drain", 4'(sb.size() != 0), 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
